vga_capture_8: RTL
==================

# vga_capture_8

Single-clock VGA receiver and frame decimator that watches a 640x480 VGA-timed pixel stream (active-low syncs, 4-bit RGB) and writes one RGB332 byte per 16x16 pixel block into a 4096-entry byte buffer. It sits on the video input side of the design and drives the same address/data/write-enable buffer port the VRAM presents to the CPU, so a captured frame lands in the same 64x64 tile layout the display side reads. Capture runs one frame per `start` request under a small state machine with done and sync-loss reporting.

## Interface
- `C_WIDTH`, 640: active pixels per line
- `C_HEIGHT`, 480: active lines per frame
- `C_H_BACK`, 48: pixel clocks from hs rising edge to first active pixel
- `C_V_BACK`, 33: hs rising edges from vs rising edge to first active line
- `C_H_TIMEOUT`, 1023: hcnt saturation value that signals sync loss
- `clk`  in  1  pixel/system clock, the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `vga_hs`  in  1  horizontal sync, active low
- `vga_vs`  in  1  vertical sync, active low
- `vga_r`, `vga_g`, `vga_b`  in  4 each  pixel colour
- `start`  in  1  one-cycle request: capture the next full frame
- `busy`  out  1  high in ARMED or CAPTURE
- `done`  out  1  high in DONE
- `error`  out  1  high in ERROR
- `write_count`  out  32  writes issued in the current or last capture
- `data_address`  out  32  buffer write address, {20'b0, y_blk[5:0], x_blk[5:0]}
- `data_din`  out  8  RGB332 byte {r[3:1], g[3:1], b[3:2]}
- `data_we`  out  1  one-cycle write strobe

## Operation
- Stage s1 registers hs/vs/rgb. Stage s2 holds the previous hs/vs. hs_rise = s1.hs & ~s2.hs. vs_rise = s1.vs & ~s2.vs.
- hcnt (10 bit): cleared to 0 on hs_rise, otherwise increments and saturates at C_H_TIMEOUT. The s1 sample at hs_rise is h=0.
- vcnt (10 bit): cleared on vs_rise, which wins over a coincident hs_rise. Otherwise increments on each hs_rise and saturates at 1023.
- Active pixel: C_H_BACK ≤ hcnt < C_H_BACK+C_WIDTH and C_V_BACK ≤ vcnt < C_V_BACK+C_HEIGHT.
  - x = hcnt−C_H_BACK, y = vcnt−C_V_BACK.
  - Sample point: x[3:0]==0 and y[3:0]==0, giving x_blk = x[9:4] (0..39) and y_blk = y[9:4] (0..29).
- States:
  - IDLE: `start` → ARMED.
  - ARMED: vs_rise → CAPTURE, write_count cleared to 0.
  - CAPTURE: the write port is active. vs_rise → DONE. hcnt == C_H_TIMEOUT → ERROR.
  - DONE / ERROR: held until `start` → ARMED.
- `start` in ARMED or CAPTURE is ignored.
- Writes occur only in CAPTURE at sample points. Each write increments write_count. A default frame yields exactly 1200 writes.
- In ERROR, no further writes are issued. write_count holds its value.
- Async reset mid-capture aborts immediately. There is no partial-frame recovery.

## Timing
- Reset values:
  - data_we 0, data_address 0, data_din 0.
  - busy 0, done 0, error 0, write_count 0.
  - State IDLE. hcnt, vcnt and the sync history are 0; s1/s2 sync bits reset to 1 (idle-high).
- Latency: a pin sample at rising edge t is in s1 after t. data_we/data_address/data_din are registered and valid for exactly one cycle after edge t+2.
- data_address and data_din hold their last values between strobes.
- done/error rise on the clock edge after the triggering vs_rise or timeout cycle.
- busy falls on that same edge.
- At most one write every 16 cycles. There is no backpressure and the buffer port never stalls.

## Test plan
- Reset, then one standard frame with `start` pulsed during line 100 → no writes until the next vs rising edge. The following frame gives 1200 strobes, and done=1 one cycle after the subsequent vs_rise.
- Pixel at x=16, y=32 set to r=0xF, g=0x8, b=0x4; all others 0 → write with address 0x081 and din 0xF1. All other blocks get din 0x00.
- Pixel at x=639, y=479 set to white → address 0x767 receives 0x00. The last write is address 0x767 (y_blk 29, x_blk 39).
- hs held low for 1100 cycles mid-CAPTURE → error=1, busy=0, no strobes after the error. A `start` pulse then gives ARMED and busy=1.
- Assert reset_n low mid-CAPTURE → all outputs 0 immediately. After release, no writes occur until `start` plus a vs_rise.
- vs_rise and hs_rise in the same cycle → vcnt=0, not 1. Verified by the first write landing on line C_V_BACK.

Source files
------------

// File: rtl/vga_capture_8.sv
`default_nettype none
// ============================================================================
// Module   : vga_capture_8
// Brief    : VGA receiver that decimates one frame into 16x16-block RGB332
//            bytes written to a 64x64-tile byte buffer.
// Revision : 1.0 - initial release
// ============================================================================
module vga_capture_8 #(
  parameter int C_WIDTH     = 640,
  parameter int C_HEIGHT    = 480,
  parameter int C_H_BACK    = 48,
  parameter int C_V_BACK    = 33,
  parameter int C_H_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] write_count,
  output logic [31:0] data_address,
  output logic [7:0]  data_din,
  output logic        data_we
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_armed   = 3'd1;
  localparam logic [2:0] c_st_capture = 3'd2;
  localparam logic [2:0] c_st_done    = 3'd3;
  localparam logic [2:0] c_st_error   = 3'd4;

  localparam logic [9:0] c_h_lo      = 10'(C_H_BACK);
  localparam logic [9:0] c_h_hi      = 10'(C_H_BACK + C_WIDTH);
  localparam logic [9:0] c_v_lo      = 10'(C_V_BACK);
  localparam logic [9:0] c_v_hi      = 10'(C_V_BACK + C_HEIGHT);
  localparam logic [9:0] c_h_timeout = 10'(C_H_TIMEOUT);
  localparam logic [9:0] c_v_max     = 10'd1023;

  logic        hs1_q, hs1_d, vs1_q, vs1_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d;
  logic [11:0] rgb1_q, rgb1_d;
  logic [7:0]  pix2_q, pix2_d;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [2:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic [31:0] wc_q, wc_d;

  logic        hs_rise, vs_rise, active, sample;
  logic [9:0]  x, y;
  logic        unused_rgb_bits;

  assign unused_rgb_bits = ^{rgb1_q[8], rgb1_q[4], rgb1_q[1:0]};

  always_comb begin
    hs1_d   = vga_hs;
    vs1_d   = vga_vs;
    rgb1_d  = {vga_r, vga_g, vga_b};
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
    // The s2 pixel travels with hcnt_q/vcnt_q, so only RGB332 bits are kept.
    pix2_d  = {rgb1_q[11:9], rgb1_q[7:5], rgb1_q[3:2]};

    hs_rise = hs1_q & ~hs2_q;
    vs_rise = vs1_q & ~vs2_q;

    hcnt_d = hcnt_q;
    if (hs_rise) begin
      hcnt_d = 10'd0;
    end else if (hcnt_q != c_h_timeout) begin
      hcnt_d = hcnt_q + 10'd1;
    end

    vcnt_d = vcnt_q;
    if (vs_rise) begin
      vcnt_d = 10'd0;
    end else if (hs_rise && (vcnt_q != c_v_max)) begin
      vcnt_d = vcnt_q + 10'd1;
    end

    x      = hcnt_q - c_h_lo;
    y      = vcnt_q - c_v_lo;
    active = (hcnt_q >= c_h_lo) && (hcnt_q < c_h_hi) &&
             (vcnt_q >= c_v_lo) && (vcnt_q < c_v_hi);
    sample = active && (x[3:0] == 4'd0) && (y[3:0] == 4'd0);

    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    wc_d    = wc_q;
    state_d = state_q;

    if ((state_q == c_st_capture) && sample) begin
      we_d   = 1'b1;
      addr_d = {y[9:4], x[9:4]};
      din_d  = pix2_q;
      wc_d   = wc_q + 32'd1;
    end

    case (state_q)
      c_st_idle: begin
        if (start) state_d = c_st_armed;
      end
      c_st_armed: begin
        if (vs_rise) begin
          state_d = c_st_capture;
          wc_d    = 32'd0;
        end
      end
      c_st_capture: begin
        if (vs_rise) begin
          state_d = c_st_done;
        end else if (hcnt_q == c_h_timeout) begin
          state_d = c_st_error;
        end
      end
      c_st_done, c_st_error: begin
        if (start) state_d = c_st_armed;
      end
      default: state_d = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      hs2_q   <= 1'b1;
      vs2_q   <= 1'b1;
      rgb1_q  <= 12'd0;
      pix2_q  <= 8'd0;
      hcnt_q  <= 10'd0;
      vcnt_q  <= 10'd0;
      state_q <= c_st_idle;
      we_q    <= 1'b0;
      addr_q  <= 12'd0;
      din_q   <= 8'd0;
      wc_q    <= 32'd0;
    end else begin
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      rgb1_q  <= rgb1_d;
      pix2_q  <= pix2_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wc_q    <= wc_d;
    end
  end

  assign busy         = (state_q == c_st_armed) || (state_q == c_st_capture);
  assign done         = (state_q == c_st_done);
  assign error        = (state_q == c_st_error);
  assign write_count  = wc_q;
  assign data_address = {20'd0, addr_q};
  assign data_din     = din_q;
  assign data_we      = we_q;

endmodule
`default_nettype wire
